// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 key decoder.
package ps2_key_decoder_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // Prefix bytes folded into the next key event
    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // Device responses and error codes, never reported as keys
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
    localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;
    localparam logic [7:0] PS2_RSP_ERR0   = 8'h00;
    localparam logic [7:0] PS2_RSP_ERR1   = 8'hFF;

    // ps2_key bit positions
    localparam int unsigned KEY_TGL = 10;
    localparam int unsigned KEY_PRS = 9;
    localparam int unsigned KEY_EXT = 8;

    // Pause sends E1 followed by seven more bytes that carry no key information
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_response(input logic [7:0] code);
        return (code == PS2_RSP_ACK)  || (code == PS2_RSP_RESEND) ||
               (code == PS2_RSP_ECHO) || (code == PS2_RSP_BAT)    ||
               (code == PS2_RSP_ERR0) || (code == PS2_RSP_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin inputs and decoded key outputs bundled for the decoder and its consumer.
interface ps2_key_decoder_if;
    logic        ps2_clk_i;
    logic        ps2_data_i;
    logic [10:0] ps2_key;
    logic        frame_err;

    // Side that drives the PS/2 lines and consumes key events
    modport master (
        output ps2_clk_i,
        output ps2_data_i,
        input  ps2_key,
        input  frame_err
    );

    // Decoder side
    modport slave (
        input  ps2_clk_i,
        input  ps2_data_i,
        output ps2_key,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_decoder_line_filter.sv
// Two-flop synchronizer, FILTER_LEN-sample debounce and falling-edge strobe for one PS/2 line.
module ps2_key_decoder_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fe
);

    localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          level_q;
    logic          fe_q;
    logic [CW-1:0] cnt_q;

    // Synchronize, then flip the level only after FILTER_LEN samples disagree in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fe_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            fe_q    <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                fe_q    <= level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign fe    = fe_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deframes device-to-host bytes and folds prefixes into ps2_key events.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_US  = 150
) (
    input  logic            clk,
    input  logic            reset,
    ps2_key_decoder_if.slave bus
);

    localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_fe;
    logic clk_level_unused;
    logic data_level;
    logic data_fe_unused;

    ps2_key_decoder_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.ps2_clk_i),
        .level (clk_level_unused),
        .fe    (clk_fe)
    );

    ps2_key_decoder_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.ps2_data_i),
        .level (data_level),
        .fe    (data_fe_unused)
    );

    ps2_state_e       state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TMO_W-1:0] tmo_q;
    logic             byte_vld_q;
    logic [7:0]       byte_q;
    logic             ext_q;
    logic             brk_q;
    logic [2:0]       skip_q;
    logic [10:0]      key_q;
    logic             err_q;

    // Frame FSM, inter-edge timeout and byte-level prefix folding
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            key_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            byte_vld_q <= 1'b0;

            if (clk_fe || (state_q == StIdle)) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
                tmo_q <= tmo_q + 1'b1;
            end

            // A PS/2 clock edge takes priority over an expiring timeout
            if (clk_fe) begin
                unique case (state_q)
                    StIdle: begin
                        if (!data_level) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {data_level, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_q <= data_level;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (data_level && (^{shift_q, parity_q})) begin
                            byte_vld_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if ((state_q != StIdle) && (tmo_q == TMO_W'(TIMEOUT_CYCLES))) begin
                state_q <= StIdle;
                err_q   <= 1'b1;
                ext_q   <= 1'b0;
                brk_q   <= 1'b0;
            end

            if (byte_vld_q) begin
                if (skip_q != '0) begin
                    skip_q <= skip_q - 1'b1;
                end else if (byte_q == PS2_PFX_PAUSE) begin
                    skip_q <= PAUSE_SKIP;
                end else if (byte_q == PS2_PFX_EXT) begin
                    ext_q <= 1'b1;
                end else if (byte_q == PS2_PFX_BRK) begin
                    brk_q <= 1'b1;
                end else if (is_response(byte_q)) begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end else begin
                    key_q[KEY_TGL] <= ~key_q[KEY_TGL];
                    key_q[KEY_PRS] <= ~brk_q;
                    key_q[KEY_EXT] <= ext_q;
                    key_q[7:0]     <= byte_q;
                    ext_q          <= 1'b0;
                    brk_q          <= 1'b0;
                end
            end
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Drives PS/2 frames at 12.5 kHz and checks ps2_key/frame_err against a byte-level model.
module tb_ps2_key_decoder;

    // 1 MHz system clock so one microsecond is one cycle (time unit: 1 cycle = 1000)
    localparam int unsigned CLK_HZ  = 1_000_000;
    localparam int          HALF    = 500;
    localparam int          US      = 1000;

    logic clk;
    logic reset;
    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .CLK_FREQ_HZ (CLK_HZ),
        .FILTER_LEN  (8),
        .TIMEOUT_US  (150)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [10:0] m_key = '0;
    bit          m_ext = 0;
    bit          m_brk = 0;
    int          m_skip = 0;
    int          m_err_exp = 0;
    logic [10:0] exp_q[$];

    // Monitor state
    logic [10:0] prev_key = '0;
    bit          prev_err = 0;
    int          err_seen = 0;
    int          n_tgl = 0;
    int          stop_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_resp(input logic [7:0] b);
        return b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'hAA || b == 8'h00 || b == 8'hFF;
    endfunction

    // Byte-level reaction of the decoder to one correctly received byte
    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (is_resp(b)) begin
            m_ext = 0;
            m_brk = 0;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            exp_q.push_back(m_key);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_err();
        m_err_exp++;
        m_ext = 0;
        m_brk = 0;
    endtask

    // Every cycle: count error pulses and match each key change against the model
    always @(negedge clk) begin
        if (reset) begin
            prev_key = bus.ps2_key;
            prev_err = 0;
        end else begin
            if (bus.frame_err) begin
                err_seen++;
                chk("frame_err_width", {31'd0, prev_err}, 32'd0);
            end
            prev_err = bus.frame_err;
            if (bus.ps2_key !== prev_key) begin
                n_tgl++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_key_change", {21'd0, bus.ps2_key}, {21'd0, prev_key});
                end else begin
                    chk("key_event", {21'd0, bus.ps2_key}, {21'd0, exp_q.pop_front()});
                end
                chk("key_latency_window",
                    {31'd0, ((cyc - stop_cyc) >= 3) && ((cyc - stop_cyc) <= 20)}, 32'd1);
                prev_key = bus.ps2_key;
            end
        end
    end

    task automatic send_bit(input logic d, input bit is_stop);
        bus.ps2_data_i = d;
        #(20 * US);
        bus.ps2_clk_i = 1'b0;
        if (is_stop) stop_cyc = cyc;
        #(40 * US);
        bus.ps2_clk_i = 1'b1;
        #(20 * US);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ flip_par;
        if (!flip_par && !bad_stop) model_byte(b);
        else model_err();
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 0);
        send_bit(par, 0);
        send_bit(~bad_stop, 1);
        bus.ps2_data_i = 1'b1;
        #(100 * US);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 0, 0);
    endtask

    task automatic checkpoint(input string name);
        @(negedge clk);
        chk({name, "_pending_events"}, exp_q.size(), 0);
        chk({name, "_err_count"}, err_seen, m_err_exp);
        chk({name, "_key"}, {21'd0, bus.ps2_key}, {21'd0, m_key});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_key", {21'd0, bus.ps2_key}, 32'd0);
        chk("reset_err", {31'd0, bus.frame_err}, 32'd0);
        m_key = '0;
        m_ext = 0;
        m_brk = 0;
        m_skip = 0;
        exp_q.delete();
        reset = 1'b0;
        #(20 * US);
    endtask

    initial begin
        int t0;
        logic [10:0] saved;
        logic [7:0]  rb;
        bus.ps2_clk_i  = 1'b1;
        bus.ps2_data_i = 1'b1;
        reset = 1'b1;
        #(5 * US);
        do_reset();

        // 1: plain make code
        send_good(8'h1A);
        checkpoint("t1");
        chk("t1_key_literal", {21'd0, bus.ps2_key}, 32'h61A);
        chk("t1_no_err", err_seen, 0);

        // 2: break prefix folds into one event
        t0 = n_tgl;
        send_good(8'hF0);
        send_good(8'h1A);
        checkpoint("t2");
        chk("t2_key_literal", {21'd0, bus.ps2_key}, 32'h01A);
        chk("t2_one_toggle", n_tgl - t0, 1);

        // 3: extended break, then plain make
        t0 = n_tgl;
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        checkpoint("t3");
        chk("t3_low_literal", {22'd0, bus.ps2_key[9:0]}, 32'h175);
        chk("t3_one_toggle", n_tgl - t0, 1);
        send_good(8'h1B);
        checkpoint("t3b");
        chk("t3b_ext", {31'd0, bus.ps2_key[8]}, 32'd0);
        chk("t3b_prs", {31'd0, bus.ps2_key[9]}, 32'd1);

        // 4: parity error
        saved = bus.ps2_key;
        t0 = err_seen;
        send_frame(8'h1A, 1, 0);
        checkpoint("t4");
        chk("t4_one_err", err_seen - t0, 1);
        chk("t4_key_held", {21'd0, bus.ps2_key}, {21'd0, saved});
        send_good(8'h1B);
        checkpoint("t4b");
        chk("t4b_code", {24'd0, bus.ps2_key[7:0]}, 32'h1B);

        // 5: truncated frame times out
        t0 = err_seen;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        bus.ps2_data_i = 1'b1;
        model_err();
        #(200 * US);
        checkpoint("t5");
        chk("t5_one_err", err_seen - t0, 1);
        send_good(8'h23);
        checkpoint("t5b");
        chk("t5b_code", {24'd0, bus.ps2_key[7:0]}, 32'h23);

        // 6a: Pause sequence produces no event
        t0 = n_tgl;
        send_good(8'hE1); send_good(8'h14); send_good(8'h77); send_good(8'hE1);
        send_good(8'hF0); send_good(8'h14); send_good(8'hF0); send_good(8'h77);
        checkpoint("t6a");
        chk("t6a_no_toggle", n_tgl - t0, 0);

        // 6b: short clock glitch with data low must not start a frame
        t0 = err_seen;
        bus.ps2_data_i = 1'b0;
        #(5 * US);
        bus.ps2_clk_i = 1'b0;
        #(3 * US);
        bus.ps2_clk_i = 1'b1;
        #(5 * US);
        bus.ps2_data_i = 1'b1;
        #(200 * US);
        send_good(8'h1C);
        checkpoint("t6b");
        chk("t6b_no_err", err_seen - t0, 0);

        // 6c: reset after an E0 prefix drops the prefix
        send_good(8'hE0);
        do_reset();
        send_good(8'h1A);
        checkpoint("t6c");
        chk("t6c_key_literal", {21'd0, bus.ps2_key}, 32'h61A);

        // Randomized traffic with occasional corrupted frames
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rb = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0;
            end else begin
                rb = 8'($urandom_range(0, 255));
            end
            send_frame(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
            if (i % 5 == 4) checkpoint("rand");
        end
        checkpoint("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
